// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants and state type for the PS/2 key tracker.
// Optional build macro: KEY_REPEAT_EN (typematic repeats re-pulse key_down).
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } state_e;

  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;
  localparam logic [7:0] SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A;
  localparam logic [7:0] SC_N = 8'h31;
  localparam logic [7:0] SC_O = 8'h44;
  localparam logic [7:0] SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15;
  localparam logic [7:0] SC_R = 8'h2D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C;
  localparam logic [7:0] SC_V = 8'h2A;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35;
  localparam logic [7:0] SC_Z = 8'h1A;

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Scan-byte input and held-key output bundle of the PS/2 key tracker.
// Optional build macro: KEY_REPEAT_EN (no effect on this file).
interface ps2_key_tracker_if;

  logic [7:0] ps2_byte;
  logic       ps2_strobe;
  logic [6:0] ascii_val;
  logic       key_held;
  logic       key_down;
  logic       key_up;

  modport master (
    output ps2_byte,
    output ps2_strobe,
    input  ascii_val,
    input  key_held,
    input  key_down,
    input  key_up
  );

  modport slave (
    input  ps2_byte,
    input  ps2_strobe,
    output ascii_val,
    output key_held,
    output key_down,
    output key_up
  );

endinterface

// File: rtl/ps2_key_tracker_scan_to_ascii.sv
// Set-2 letter scan code to uppercase ASCII lookup.
// Optional build macro: KEY_REPEAT_EN (no effect on this file).
module ps2_scan_to_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] scan_i,
  output logic [6:0] ascii_o,
  output logic       is_letter_o
);

  always_comb begin
    ascii_o     = 7'd0;
    is_letter_o = 1'b1;
    unique case (scan_i)
      SC_A: ascii_o = 7'd65;
      SC_B: ascii_o = 7'd66;
      SC_C: ascii_o = 7'd67;
      SC_D: ascii_o = 7'd68;
      SC_E: ascii_o = 7'd69;
      SC_F: ascii_o = 7'd70;
      SC_G: ascii_o = 7'd71;
      SC_H: ascii_o = 7'd72;
      SC_I: ascii_o = 7'd73;
      SC_J: ascii_o = 7'd74;
      SC_K: ascii_o = 7'd75;
      SC_L: ascii_o = 7'd76;
      SC_M: ascii_o = 7'd77;
      SC_N: ascii_o = 7'd78;
      SC_O: ascii_o = 7'd79;
      SC_P: ascii_o = 7'd80;
      SC_Q: ascii_o = 7'd81;
      SC_R: ascii_o = 7'd82;
      SC_S: ascii_o = 7'd83;
      SC_T: ascii_o = 7'd84;
      SC_U: ascii_o = 7'd85;
      SC_V: ascii_o = 7'd86;
      SC_W: ascii_o = 7'd87;
      SC_X: ascii_o = 7'd88;
      SC_Y: ascii_o = 7'd89;
      SC_Z: ascii_o = 7'd90;
      default: is_letter_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks PS/2 set-2 make/break sequences and presents the held letter.
// Optional build macro: KEY_REPEAT_EN (typematic repeats re-pulse key_down).
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter logic [6:0] ASCII_IDLE = 7'd0
) (
  input  logic              clk,
  input  logic              resetn,
  ps2_key_tracker_if.slave  bus
);

  state_e     state_q, state_d;
  logic [6:0] ascii_q, ascii_d;
  logic       held_q, held_d;
  logic       down_q, down_d;
  logic       up_q, up_d;

  logic [6:0] scan_ascii;
  logic       scan_letter;
  logic       press_ev;
  logic       rel_ev;

  ps2_scan_to_ascii u_map (
    .scan_i      (bus.ps2_byte),
    .ascii_o     (scan_ascii),
    .is_letter_o (scan_letter)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.ps2_strobe) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.ps2_byte == PS2_EXT)
            state_d = S_EXT;
          else if (bus.ps2_byte == PS2_BREAK)
            state_d = S_BREAK;
        end
        S_EXT: begin
          if (bus.ps2_byte == PS2_BREAK)
            state_d = S_EXT_BREAK;
          else
            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign press_ev = bus.ps2_strobe && scan_letter
                  && (state_q == S_IDLE);
  assign rel_ev   = bus.ps2_strobe && scan_letter
                  && (state_q == S_BREAK);

  always_comb begin
    ascii_d = ascii_q;
    held_d  = held_q;
    down_d  = 1'b0;
    up_d    = 1'b0;
    unique case (1'b1)
      press_ev: begin
        if (!held_q || ascii_q != scan_ascii) begin
          ascii_d = scan_ascii;
          held_d  = 1'b1;
          down_d  = 1'b1;
        end
`ifdef KEY_REPEAT_EN
        else begin
          down_d = 1'b1;
        end
`endif
      end
      rel_ev: begin
        // a release of any other letter leaves the held key alone
        if (held_q && ascii_q == scan_ascii) begin
          ascii_d = ASCII_IDLE;
          held_d  = 1'b0;
          up_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ascii_q <= ASCII_IDLE;
      held_q  <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      ascii_q <= ascii_d;
      held_q  <= held_d;
      down_q  <= down_d;
      up_q    <= up_d;
    end
  end

  assign bus.ascii_val = ascii_q;
  assign bus.key_held  = held_q;
  assign bus.key_down  = down_q;
  assign bus.key_up    = up_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker.
// Optional build macro: KEY_REPEAT_EN (changes repeat expectations).
module tb_ps2_key_tracker;

  logic clk;
  logic resetn;
  int   n_chk;
  int   n_err;

  ps2_key_tracker_if bus ();

  ps2_key_tracker dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

`ifdef KEY_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // drive for one cycle from a negedge, return at the next negedge
  task automatic step(input logic s, input logic [7:0] b);
    bus.ps2_strobe = s;
    bus.ps2_byte   = b;
    @(negedge clk);
    bus.ps2_strobe = 1'b0;
    bus.ps2_byte   = 8'h00;
  endtask

  task automatic outs(input string tag, input int a, input int h,
                      input int d, input int u);
    chk({tag, ".ascii"}, int'(bus.ascii_val), a);
    chk({tag, ".held"},  int'(bus.key_held),  h);
    chk({tag, ".down"},  int'(bus.key_down),  d);
    chk({tag, ".up"},    int'(bus.key_up),    u);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    resetn = 1'b0;
    bus.ps2_strobe = 1'b0;
    bus.ps2_byte   = 8'h00;
    @(negedge clk);

    step(1'b1, 8'h1C);
    outs("rst_strobe", 0, 0, 0, 0);
    step(1'b1, 8'hF0);
    outs("rst_strobe2", 0, 0, 0, 0);
    resetn = 1'b1;

    step(1'b1, 8'h1C);
    outs("pressA", 65, 1, 1, 0);
    step(1'b0, 8'h00);
    outs("pressA_hold", 65, 1, 0, 0);
    step(1'b1, 8'hF0);
    outs("relA_f0", 65, 1, 0, 0);
    step(1'b1, 8'h1C);
    outs("relA", 0, 0, 0, 1);
    step(1'b0, 8'h00);
    outs("relA_after", 0, 0, 0, 0);

    step(1'b1, 8'h1D);
    outs("W_make", 87, 1, 1, 0);
    step(1'b1, 8'hF0);
    outs("W_f0", 87, 1, 0, 0);
    step(1'b1, 8'h1D);
    outs("W_break", 0, 0, 0, 1);
    step(1'b0, 8'h00);
    outs("W_idle", 0, 0, 0, 0);

    step(1'b1, 8'h1C);
    outs("roll_A", 65, 1, 1, 0);
    step(1'b1, 8'h1B);
    outs("roll_S", 83, 1, 1, 0);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h1C);
    outs("roll_relA", 83, 1, 0, 0);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h16);
    outs("roll_rel1", 83, 1, 0, 0);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h1B);
    outs("roll_relS", 0, 0, 0, 1);

    step(1'b1, 8'h1C);
    outs("rep1", 65, 1, 1, 0);
    step(1'b1, 8'h1C);
    outs("rep2", 65, 1, REP, 0);
    step(1'b1, 8'h1C);
    outs("rep3", 65, 1, REP, 0);
    step(1'b0, 8'h00);
    outs("rep_idle", 65, 1, 0, 0);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h1C);
    outs("rep_rel", 0, 0, 0, 1);

    step(1'b1, 8'hE0);
    step(1'b1, 8'h1C);
    outs("ext_make", 0, 0, 0, 0);
    step(1'b1, 8'hE0);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h1C);
    outs("ext_break", 0, 0, 0, 0);
    step(1'b1, 8'hFA);
    step(1'b1, 8'hAA);
    step(1'b1, 8'h16);
    outs("junk", 0, 0, 0, 0);
    step(1'b1, 8'h34);
    outs("G_make", 71, 1, 1, 0);
    step(1'b1, 8'hE0);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h34);
    outs("G_extrel", 71, 1, 0, 0);
    step(1'b1, 8'hF0);
    step(1'b1, 8'h34);
    outs("G_rel", 0, 0, 0, 1);

    step(1'b1, 8'h2B);
    outs("F_make", 70, 1, 1, 0);
    step(1'b1, 8'hF0);
    resetn = 1'b0;
    step(1'b0, 8'h00);
    outs("mid_rst", 0, 0, 0, 0);
    resetn = 1'b1;
    step(1'b1, 8'h2B);
    outs("F_after_rst", 70, 1, 1, 0);
    step(1'b0, 8'h00);
    outs("F_hold", 70, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
